// File: rtl/nes_pad_reader_if.sv
// rtl/nes_pad_reader_if.sv - pad wire and decoded-state bundle for nes_pad_reader
//
// Purpose: groups the serial pad lines and the published button/direction
// state so the reader, the pad and the input selector share one port.
//   PAD_DATA   pad -> reader  serial data, active-low, asynchronous
//   PAD_LATCH  reader -> pad  latch strobe, active-high
//   PAD_CLK    reader -> pad  shift clock, idles high
//   NU/ND/NL/NR, NReadable, Buttons[NBITS], FrameDone  reader -> consumer
// Build option: NES_PAD_SNES_EN selects the 16-bit SNES frame (NBITS = 16).

interface nes_pad_reader_if;
`ifdef NES_PAD_SNES_EN
  localparam int NBITS = 16;
`else
  localparam int NBITS = 8;
`endif

  logic             PAD_DATA;
  logic             PAD_LATCH;
  logic             PAD_CLK;
  logic             NU;
  logic             ND;
  logic             NL;
  logic             NR;
  logic             NReadable;
  logic [NBITS-1:0] Buttons;
  logic             FrameDone;

  modport master (
    input  PAD_DATA,
    output PAD_LATCH, PAD_CLK, NU, ND, NL, NR, NReadable, Buttons, FrameDone
  );

  modport slave (
    output PAD_DATA,
    input  PAD_LATCH, PAD_CLK, NU, ND, NL, NR, NReadable, Buttons, FrameDone
  );
endinterface

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - NES/SNES serial game pad poller
//
// Purpose: periodically latches and clocks a serial game pad, shifts in the
// active-low button bits, checks the trailing presence bit and publishes a
// frame-atomic snapshot of buttons and directions.
// Ports:
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   bus    nes_pad_reader_if.master (PAD_DATA in; PAD_LATCH, PAD_CLK,
//          NU/ND/NL/NR, NReadable, Buttons, FrameDone out)
// Build option: NES_PAD_SNES_EN selects a 16-bit SNES frame; the top four
// bits are reserved and always published as 0.

module nes_pad_reader #(
  parameter int TICK_DIV   = 300,
  parameter int POLL_TICKS = 2778
) (
  input  logic             CLK,
  input  logic             RST_N,
  nes_pad_reader_if.master bus
);

`ifdef NES_PAD_SNES_EN
  localparam int               NBITS    = 16;
  localparam logic [NBITS-1:0] BTN_MASK = 16'h0FFF;
`else
  localparam int               NBITS    = 8;
  localparam logic [NBITS-1:0] BTN_MASK = 8'hFF;
`endif

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(POLL_TICKS + 1);
  localparam int KW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SAMPLE,
    S_PULSE,
    S_UPDATE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [TW-1:0]    tick_q, tick_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] buttons_q, buttons_d;
  logic             readable_q, readable_d;
  logic             latch_q, pclk_q, done_q;
  logic             data_s;
  logic             strobe;

  assign data_s = sync_q[1];
  assign strobe = (tick_q == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      tick_q     <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      readable_q <= 1'b0;
      latch_q    <= 1'b0;
      pclk_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], bus.PAD_DATA};
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      readable_q <= readable_d;
      // Pad-facing strobes are registered from the next state so the wires
      // never glitch on a multi-bit state change.
      latch_q    <= (state_d == S_LATCH);
      pclk_q     <= (state_d != S_PULSE);
      done_q     <= (state_d == S_UPDATE);
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = strobe ? '0 : tick_q + TW'(1);
    cnt_d      = cnt_q;
    k_d        = k_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    readable_d = readable_q;

    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (cnt_q == PW'(POLL_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = S_LATCH;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      S_LATCH: begin
        if (strobe) begin
          if (cnt_q == PW'(1)) begin
            cnt_d   = '0;
            k_d     = '0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      S_SAMPLE: begin
        if (strobe) begin
          if (k_q == KW'(NBITS)) begin
            // Presence bit: a grounded serial-in reads low; a missing pad
            // floats or is pulled high. Outputs load here so they are
            // already valid during the one-cycle UPDATE/FrameDone window.
            if (!data_s) begin
              buttons_d  = shift_q & BTN_MASK;
              readable_d = 1'b1;
            end else begin
              buttons_d  = '0;
              readable_d = 1'b0;
            end
            state_d = S_UPDATE;
          end else begin
            // Shift right so the first bit clocked out lands in bit 0.
            shift_d = {~data_s, shift_q[NBITS-1:1]};
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (strobe) begin
          k_d     = k_q + KW'(1);
          state_d = S_SAMPLE;
        end
      end
      S_UPDATE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.PAD_LATCH = latch_q;
  assign bus.PAD_CLK   = pclk_q;
  assign bus.FrameDone = done_q;
  assign bus.Buttons   = buttons_q;
  assign bus.NReadable = readable_q;
  assign bus.NU        = buttons_q[4];
  assign bus.ND        = buttons_q[5];
  assign bus.NL        = buttons_q[6];
  assign bus.NR        = buttons_q[7];

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb/tb_nes_pad_reader.sv - scoreboard bench for nes_pad_reader

module tb_nes_pad_reader;
  localparam int TD = 4;
  localparam int PT = 10;
`ifdef NES_PAD_SNES_EN
  localparam int NB = 16;
`else
  localparam int NB = 8;
`endif
  localparam int NV        = 9;
  localparam int ABORT_IDX = 6;

  // Directed vectors: pressed mask (1 = pressed, bit 0 shifted first), pad
  // plugged, unplug after N PAD_CLK rises (-1 = never), expected Buttons/NReadable.
`ifdef NES_PAD_SNES_EN
  localparam logic [15:0] V_PRESS [NV] = '{16'hF110, 16'hFFFF, 16'h0040, 16'h0040, 16'h0A31,
                                          16'hFFFF, 16'h005A, 16'h800C, 16'h0081};
  localparam logic [15:0] V_EXP   [NV] = '{16'h0110, 16'h0000, 16'h0040, 16'h0000, 16'h0A31,
                                          16'h0FFF, 16'h0000, 16'h000C, 16'h0000};
`else
  localparam logic [15:0] V_PRESS [NV] = '{16'h0090, 16'h00FF, 16'h0040, 16'h0040, 16'h0031,
                                          16'h00FF, 16'h005A, 16'h000C, 16'h0081};
  localparam logic [15:0] V_EXP   [NV] = '{16'h0090, 16'h0000, 16'h0040, 16'h0000, 16'h0031,
                                          16'h00FF, 16'h0000, 16'h000C, 16'h0000};
`endif
  localparam logic V_PLUG [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam int   V_UA   [NV] = '{-1, -1, -1, -1, -1, -1, -1, -1, 3};
  localparam logic V_RD   [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic [15:0] btn;
    logic        rd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nes_pad_reader_if bus ();

  nes_pad_reader #(.TICK_DIV(TD), .POLL_TICKS(PT)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pad model: latch reloads the bit index, each PAD_CLK rise advances it;
  // past the last button the grounded serial-in reads 0.
  logic [15:0] pad_btn     = 16'h0;
  logic        pad_plugged = 1'b1;
  int          unplug_at   = -1;
  int          pad_idx     = 0;
  logic [15:0] pad_sh;

  initial forever begin
    @(posedge bus.PAD_CLK or posedge bus.PAD_LATCH);
    if (bus.PAD_LATCH) pad_idx = 0;
    else               pad_idx = pad_idx + 1;
  end

  assign pad_sh       = pad_btn >> pad_idx;
  assign bus.PAD_DATA = (!pad_plugged || (unplug_at >= 0 && pad_idx >= unplug_at)) ? 1'b1 :
                        (pad_idx < NB) ? ~pad_sh[0] : 1'b0;

  // Monitor: waveform timing, hold-between-updates, and scoreboard pops.
  int   cyc = 0, latch_rise = 0, latch_w = 0, pulses = 0, curw = 0, wmin = 0, wmax = 0;
  logic latch_prev = 1'b0, pclk_prev = 1'b1, done_prev = 1'b0;
  logic first_frame = 1'b1, have_prev = 1'b0, hold_ok = 1'b1;
  logic [NB-1:0] prev_btn;
  logic [4:0]    prev_misc;
  exp_t          e;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cyc = 0; first_frame = 1'b1; have_prev = 1'b0; hold_ok = 1'b1;
      latch_prev = 1'b0; pclk_prev = 1'b1; done_prev = 1'b0; pulses = 0;
    end else begin
      cyc++;
      if (bus.PAD_LATCH && !latch_prev) begin
        latch_rise = cyc; latch_w = 0; pulses = 0; wmin = 999; wmax = 0;
      end
      if (bus.PAD_LATCH) latch_w++;
      if (!bus.PAD_CLK) begin
        if (pclk_prev) begin pulses++; curw = 0; end
        curw++;
      end else if (!pclk_prev) begin
        if (curw < wmin) wmin = curw;
        if (curw > wmax) wmax = curw;
      end
      if (!bus.FrameDone && have_prev &&
          (bus.Buttons !== prev_btn ||
           {bus.NReadable, bus.NU, bus.ND, bus.NL, bus.NR} !== prev_misc))
        hold_ok = 1'b0;
      if (bus.FrameDone) begin
        if (first_frame) check("latch_rise_cycle", latch_rise, PT * TD);
        first_frame = 1'b0;
        check("latch_width", latch_w, 2 * TD);
        check("pclk_pulses", pulses, NB);
        check("pclk_wmin", wmin, TD);
        check("pclk_wmax", wmax, TD);
        check("done_single", done_prev, 0);
        check("hold_between_updates", hold_ok, 1);
        check("sb_pending", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("buttons", bus.Buttons, e.btn[NB-1:0]);
          check("readable", bus.NReadable, e.rd);
          check("nu", bus.NU, e.btn[4]);
          check("nd", bus.ND, e.btn[5]);
          check("nl", bus.NL, e.btn[6]);
          check("nr", bus.NR, e.btn[7]);
        end
        prev_btn  = bus.Buttons;
        prev_misc = {bus.NReadable, bus.NU, bus.ND, bus.NL, bus.NR};
        have_prev = 1'b1;
        hold_ok   = 1'b1;
      end
      latch_prev = bus.PAD_LATCH;
      pclk_prev  = bus.PAD_CLK;
      done_prev  = bus.FrameDone;
    end
  end

  task automatic load_vec(input int i);
    pad_btn     = V_PRESS[i];
    pad_plugged = V_PLUG[i];
    unplug_at   = V_UA[i];
    if (i != ABORT_IDX) sb_q.push_back('{btn: V_EXP[i], rd: V_RD[i]});
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_latch"}, bus.PAD_LATCH, 0);
    check({tag, "_pclk"}, bus.PAD_CLK, 1);
    check({tag, "_readable"}, bus.NReadable, 0);
    check({tag, "_buttons"}, bus.Buttons, 0);
    check({tag, "_dirs"}, {bus.NU, bus.ND, bus.NL, bus.NR}, 0);
    check({tag, "_done"}, bus.FrameDone, 0);
  endtask

  initial begin
    logic seen;
    load_vec(0);
    repeat (3) @(negedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) load_vec(i);
      seen = 1'b0;
      if (i == ABORT_IDX) begin
        for (int n = 0; n < 600 && !seen; n++) begin
          @(negedge clk); #1;
          if (pulses == 5 && !bus.PAD_CLK) seen = 1'b1;
        end
        check("fifth_pulse_seen", seen, 1);
        check("abort_pre_readable", bus.NReadable, 1);
        #1 rst_n = 1'b0;
        #1;
        reset_checks("abort");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
      end else begin
        for (int n = 0; n < 600 && !seen; n++) begin
          @(negedge clk);
          if (bus.FrameDone) seen = 1'b1;
        end
        check("frame_done_seen", seen, 1);
      end
    end
    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
